regfile_sequencer: RTL and testbench

Initiator-side controller for the 32x32 floating-point register file. It accepts one instruction at a time over a valid/ready handshake and reads two source registers with `rs1`/`rs2`/`rf`. It hands the operands to the FP execution unit, waits for the result, then writes it back with `ws`/`wd`/`wf`. All register-file control outputs are registered, so the level-sensitive write port never sees glitching `ws`, `wd` or `wf`.

---
 rtl/fp_core_pkg.sv | 28 ++
 rtl/regfile_sequencer.sv | 135 +++++++++++++
 tb/tb_regfile_sequencer.sv | 389 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_core_pkg.sv
// Shared definitions for the FP core: sequencer state encoding, default widths
// and the opcode values understood by the execution unit.
package fp_core_pkg;

  localparam int FP_ADDR_W = 5;
  localparam int FP_DATA_W = 32;
  localparam int FP_OP_W   = 4;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_READ  = 3'd1;
  localparam logic [2:0] ST_ISSUE = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_WRITE = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    READ  = ST_READ,
    ISSUE = ST_ISSUE,
    WAIT  = ST_WAIT,
    WRITE = ST_WRITE
  } seq_state_e;

  localparam logic [FP_OP_W-1:0] OP_ADD = 4'd0;
  localparam logic [FP_OP_W-1:0] OP_SUB = 4'd1;
  localparam logic [FP_OP_W-1:0] OP_MUL = 4'd2;
  localparam logic [FP_OP_W-1:0] OP_DIV = 4'd3;

endpackage

// File: rtl/regfile_sequencer.sv
// Single-issue sequencer: read two FP registers, hand them to the execution unit,
// collect the result and optionally write it back through registered rf/wf ports.
module regfile_sequencer
  import fp_core_pkg::*;
#(
  parameter int ADDR_W = FP_ADDR_W,
  parameter int DATA_W = FP_DATA_W,
  parameter int OP_W   = FP_OP_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [OP_W-1:0]   instr_op,
  input  logic [ADDR_W-1:0] instr_rs1,
  input  logic [ADDR_W-1:0] instr_rs2,
  input  logic [ADDR_W-1:0] instr_rd,
  input  logic              instr_wb,
  output logic [ADDR_W-1:0] rs1,
  output logic [ADDR_W-1:0] rs2,
  output logic              rf,
  input  logic [DATA_W-1:0] rd1,
  input  logic [DATA_W-1:0] rd2,
  output logic [ADDR_W-1:0] ws,
  output logic [DATA_W-1:0] wd,
  output logic              wf,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [OP_W-1:0]   ex_op,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  input  logic              res_valid,
  output logic              res_ready,
  input  logic [DATA_W-1:0] res_data,
  output logic              busy,
  output logic [CNT_W-1:0]  retire_count
);

  seq_state_e        state_q;
  logic [ADDR_W-1:0] rs1_q, rs2_q, rd_q, ws_q;
  logic [DATA_W-1:0] wd_q, ex_a_q, ex_b_q;
  logic [OP_W-1:0]   ex_op_q;
  logic              wb_q, rf_q, wf_q, ex_valid_q, res_ready_q;
  logic [CNT_W-1:0]  retire_q, retire_d;

  assign retire_d = retire_q + CNT_W'(1);

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments here so every register samples pre-edge
    // values regardless of statement order within the block.
    if (reset) begin
      state_q     <= IDLE;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      ws_q        <= '0;
      wd_q        <= '0;
      ex_a_q      <= '0;
      ex_b_q      <= '0;
      ex_op_q     <= '0;
      wb_q        <= 1'b0;
      rf_q        <= 1'b0;
      wf_q        <= 1'b0;
      ex_valid_q  <= 1'b0;
      res_ready_q <= 1'b0;
      retire_q    <= '0;
    end else begin
      // rf and wf are one-cycle strobes; only the entering transition raises them.
      rf_q <= 1'b0;
      wf_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (instr_valid) begin
            ex_op_q <= instr_op;
            rs1_q   <= instr_rs1;
            rs2_q   <= instr_rs2;
            rd_q    <= instr_rd;
            wb_q    <= instr_wb;
            rf_q    <= 1'b1;
            state_q <= READ;
          end
        end
        READ: begin
          ex_a_q     <= rd1;
          ex_b_q     <= rd2;
          ex_valid_q <= 1'b1;
          state_q    <= ISSUE;
        end
        ISSUE: begin
          if (ex_ready) begin
            ex_valid_q  <= 1'b0;
            res_ready_q <= 1'b1;
            state_q     <= WAIT;
          end
        end
        WAIT: begin
          if (res_valid) begin
            res_ready_q <= 1'b0;
            if (wb_q) begin
              wd_q    <= res_data;
              ws_q    <= rd_q;
              wf_q    <= 1'b1;
              state_q <= WRITE;
            end else begin
              retire_q <= retire_d;
              state_q  <= IDLE;
            end
          end
        end
        WRITE: begin
          retire_q <= retire_d;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign instr_ready  = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign rs1          = rs1_q;
  assign rs2          = rs2_q;
  assign rf           = rf_q;
  assign ws           = ws_q;
  assign wd           = wd_q;
  assign wf           = wf_q;
  assign ex_valid     = ex_valid_q;
  assign ex_op        = ex_op_q;
  assign ex_a         = ex_a_q;
  assign ex_b         = ex_b_q;
  assign res_ready    = res_ready_q;
  assign retire_count = retire_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Bench for regfile_sequencer: behavioural register file, stallable execution-unit
// model, and a scoreboard of expected operand transfers and write-backs.
module tb_regfile_sequencer;
  import fp_core_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        instr_valid = 1'b0;
  logic [3:0]  instr_op = '0;
  logic [4:0]  instr_rs1 = '0, instr_rs2 = '0, instr_rd = '0;
  logic        instr_wb = 1'b0;
  logic        ex_ready, res_valid;
  logic [31:0] res_data;
  logic [31:0] rd1, rd2;

  wire         instr_ready, rf, wf, ex_valid, res_ready, busy;
  wire [4:0]   rs1, rs2, ws;
  wire [31:0]  wd, ex_a, ex_b;
  wire [3:0]   ex_op;
  wire [15:0]  retire_count;

  wire         s_instr_ready, s_rf, s_wf, s_ex_valid, s_res_ready, s_busy;
  wire [4:0]   s_rs1, s_rs2, s_ws;
  wire [31:0]  s_wd, s_ex_a, s_ex_b;
  wire [3:0]   s_ex_op;
  wire [3:0]   s_retire_count;

  always #5 clk = ~clk;

  regfile_sequencer dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_rs1(instr_rs1), .instr_rs2(instr_rs2), .instr_rd(instr_rd),
    .instr_wb(instr_wb), .rs1(rs1), .rs2(rs2), .rf(rf), .rd1(rd1), .rd2(rd2),
    .ws(ws), .wd(wd), .wf(wf), .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op),
    .ex_a(ex_a), .ex_b(ex_b), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .busy(busy), .retire_count(retire_count)
  );

  // Narrow-counter twin so counter wrap is reachable in a short run.
  regfile_sequencer #(.CNT_W(4)) dut_small (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(s_instr_ready),
    .instr_op(instr_op), .instr_rs1(instr_rs1), .instr_rs2(instr_rs2), .instr_rd(instr_rd),
    .instr_wb(instr_wb), .rs1(s_rs1), .rs2(s_rs2), .rf(s_rf), .rd1(rd1), .rd2(rd2),
    .ws(s_ws), .wd(s_wd), .wf(s_wf), .ex_valid(s_ex_valid), .ex_ready(ex_ready),
    .ex_op(s_ex_op), .ex_a(s_ex_a), .ex_b(s_ex_b), .res_valid(res_valid),
    .res_ready(s_res_ready), .res_data(res_data), .busy(s_busy),
    .retire_count(s_retire_count)
  );

  int tests_run = 0;
  int tests_failed = 0;
  int n_xfer = 0;

  // Register file: combinational read, write at the edge ending a wf cycle.
  logic [31:0] regs [32];
  logic        bd_we = 1'b0;
  logic [4:0]  bd_addr = '0;
  logic [31:0] bd_data = '0;
  assign rd1 = regs[rs1];
  assign rd2 = regs[rs2];
  always @(posedge clk) begin
    if (wf) regs[ws] <= wd;
    else if (bd_we) regs[bd_addr] <= bd_data;
  end

  // Execution-unit model, reacting just after the falling edge.
  int          ex_stall = 0;
  int          stall_cnt = 0;
  logic        res_en = 1'b1;
  logic [31:0] alu_res = '0;
  initial begin
    ex_ready  = 1'b0;
    res_valid = 1'b0;
    res_data  = '0;
    forever begin
      @(negedge clk);
      #1;
      if (ex_valid) begin
        if (stall_cnt < ex_stall) begin
          ex_ready = 1'b0;
          stall_cnt++;
        end else begin
          ex_ready = 1'b1;
        end
      end else begin
        ex_ready  = 1'b0;
        stall_cnt = 0;
      end
      res_valid = res_ready & res_en;
      res_data  = res_valid ? alu_res : 32'hDEAD_BEEF;
    end
  end

  typedef struct packed { logic [3:0] op; logic [31:0] a; logic [31:0] b; } opnd_t;
  typedef struct packed { logic [4:0] rd; logic [31:0] d; } wr_t;
  opnd_t exp_opnd[$];
  wr_t   exp_wr[$];

  // Scoreboard monitor: operand transfers and write-backs.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (ex_valid && ex_ready) begin
        n_xfer++;
        tests_run++;
        if (exp_opnd.size() == 0) begin
          tests_failed++;
          $display("FAIL operands: unexpected transfer a=%h b=%h", ex_a, ex_b);
        end else begin
          opnd_t e;
          e = exp_opnd.pop_front();
          if ({ex_op, ex_a, ex_b} !== e) begin
            tests_failed++;
            $display("FAIL operands: got op=%h a=%h b=%h expected op=%h a=%h b=%h",
                     ex_op, ex_a, ex_b, e.op, e.a, e.b);
          end
        end
      end
      if (wf) begin
        tests_run++;
        if (exp_wr.size() == 0) begin
          tests_failed++;
          $display("FAIL writeback: unexpected wf ws=%0d wd=%h", ws, wd);
        end else begin
          wr_t w;
          w = exp_wr.pop_front();
          if ({ws, wd} !== w) begin
            tests_failed++;
            $display("FAIL writeback: got ws=%0d wd=%h expected ws=%0d wd=%h", ws, wd, w.rd, w.d);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic poke(input logic [4:0] a, input logic [31:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!instr_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (!instr_ready) begin
      tests_failed++;
      $display("FAIL idle_timeout: instr_ready=%b after %0d cycles, expected 1", instr_ready, n);
    end
  endtask

  // Offer one instruction at a falling edge; returns at the falling edge of T+1.
  task automatic issue(input logic [3:0] op, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [4:0] rd, input logic wb, input logic [31:0] ea,
                       input logic [31:0] eb, input logic [31:0] res, input logic expect_wr);
    wait_idle();
    instr_valid = 1'b1; instr_op = op; instr_rs1 = a1; instr_rs2 = a2;
    instr_rd = rd; instr_wb = wb; alu_res = res;
    exp_opnd.push_back('{op: op, a: ea, b: eb});
    if (expect_wr) exp_wr.push_back('{rd: rd, d: res});
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({instr_ready, busy, rf, wf, ex_valid, res_ready} !== 6'b100000) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got rdy/busy/rf/wf/exv/resr=%b expected 100000",
               {instr_ready, busy, rf, wf, ex_valid, res_ready});
    end
    tests_run++;
    if ({retire_count, ws, wd, rs1, rs2, ex_a, ex_b, ex_op} !== '0) begin
      tests_failed++;
      $display("FAIL reset_data: got cnt=%h ws=%h wd=%h rs1=%h rs2=%h a=%h b=%h op=%h expected all 0",
               retire_count, ws, wd, rs1, rs2, ex_a, ex_b, ex_op);
    end
  endtask

  task automatic test_basic_add();
    issue(OP_ADD, 5'd1, 5'd2, 5'd20, 1'b1, 32'h4110_0000, 32'h4222_0000, 32'h4246_0000, 1'b1);
    tests_run++;
    if ({rf, rs1, rs2, instr_ready} !== {1'b1, 5'd1, 5'd2, 1'b0}) begin
      tests_failed++;
      $display("FAIL basic_t1: got rf=%b rs1=%0d rs2=%0d rdy=%b expected rf=1 rs1=1 rs2=2 rdy=0",
               rf, rs1, rs2, instr_ready);
    end
    @(negedge clk);
    tests_run++;
    if ({ex_valid, rf, ex_a, ex_b} !== {1'b1, 1'b0, 32'h4110_0000, 32'h4222_0000}) begin
      tests_failed++;
      $display("FAIL basic_t2: got exv=%b rf=%b a=%h b=%h expected exv=1 rf=0 a=41100000 b=42220000",
               ex_valid, rf, ex_a, ex_b);
    end
    @(negedge clk);
    tests_run++;
    if ({res_ready, ex_valid, wf} !== 3'b100) begin
      tests_failed++;
      $display("FAIL basic_t3: got resr/exv/wf=%b expected 100", {res_ready, ex_valid, wf});
    end
    @(negedge clk);
    tests_run++;
    if ({wf, ws, wd} !== {1'b1, 5'd20, 32'h4246_0000}) begin
      tests_failed++;
      $display("FAIL basic_t4: got wf=%b ws=%0d wd=%h expected wf=1 ws=20 wd=42460000", wf, ws, wd);
    end
    @(negedge clk);
    tests_run++;
    if ({instr_ready, wf, ws, wd, retire_count} !== {1'b1, 1'b0, 5'd20, 32'h4246_0000, 16'd1}) begin
      tests_failed++;
      $display("FAIL basic_t5: got rdy=%b wf=%b ws=%0d wd=%h cnt=%0d expected rdy=1 wf=0 ws=20 wd=42460000 cnt=1",
               instr_ready, wf, ws, wd, retire_count);
    end
    tests_run++;
    if (regs[20] !== 32'h4246_0000) begin
      tests_failed++;
      $display("FAIL basic_r20: got %h expected 42460000", regs[20]);
    end
  endtask

  task automatic test_stall();
    int  x0 = n_xfer;
    int  wf_at = -1;
    bit  stable = 1'b1;
    ex_stall = 3;
    issue(OP_MUL, 5'd1, 5'd2, 5'd21, 1'b1, 32'h4110_0000, 32'h4222_0000, 32'h43B6_4000, 1'b1);
    for (int k = 2; k <= 12; k++) begin
      @(negedge clk);
      if (k <= 5 && {ex_valid, ex_op, ex_a, ex_b} !== {1'b1, OP_MUL, 32'h4110_0000, 32'h4222_0000})
        stable = 1'b0;
      if (wf && wf_at < 0) wf_at = k;
    end
    ex_stall = 0;
    tests_run++;
    if (!stable) begin
      tests_failed++;
      $display("FAIL stall_stable: ex_valid/ex_op/ex_a/ex_b changed while ex_ready low");
    end
    tests_run++;
    if (wf_at != 7) begin
      tests_failed++;
      $display("FAIL stall_wf: wf at T+%0d expected T+7", wf_at);
    end
    tests_run++;
    if (n_xfer - x0 != 1) begin
      tests_failed++;
      $display("FAIL stall_xfer: got %0d transfers expected 1", n_xfer - x0);
    end
  endtask

  task automatic test_no_wb();
    logic [15:0] c0;
    bit          saw_wf = 1'b0;
    logic        rdy3, rdy4;
    poke(5'd5, 32'h1234_5678);
    c0 = retire_count;
    issue(OP_SUB, 5'd1, 5'd2, 5'd5, 1'b0, 32'h4110_0000, 32'h4222_0000, 32'hC1FC_0000, 1'b0);
    if (wf) saw_wf = 1'b1;
    @(negedge clk); if (wf) saw_wf = 1'b1;
    @(negedge clk); if (wf) saw_wf = 1'b1; rdy3 = instr_ready;
    @(negedge clk); if (wf) saw_wf = 1'b1; rdy4 = instr_ready;
    tests_run++;
    if ({rdy3, rdy4} !== 2'b01) begin
      tests_failed++;
      $display("FAIL nowb_ready: got rdy T+3/T+4=%b expected 01", {rdy3, rdy4});
    end
    tests_run++;
    if (saw_wf) begin
      tests_failed++;
      $display("FAIL nowb_wf: got wf pulse expected none");
    end
    tests_run++;
    if (retire_count !== c0 + 16'd1) begin
      tests_failed++;
      $display("FAIL nowb_count: got %0d expected %0d", retire_count, c0 + 16'd1);
    end
    tests_run++;
    if (regs[5] !== 32'h1234_5678) begin
      tests_failed++;
      $display("FAIL nowb_r5: got %h expected 12345678", regs[5]);
    end
  endtask

  task automatic test_hazard();
    poke(5'd3, 32'h42F3_0000);
    issue(OP_DIV, 5'd3, 5'd3, 5'd3, 1'b1, 32'h42F3_0000, 32'h42F3_0000, 32'h3F80_0000, 1'b1);
    wait_idle();
    tests_run++;
    if (regs[3] !== 32'h3F80_0000) begin
      tests_failed++;
      $display("FAIL hazard_r3: got %h expected 3f800000", regs[3]);
    end
  endtask

  task automatic test_reset_abort();
    int n = 0;
    poke(5'd7, 32'hAAAA_5555);
    res_en = 1'b0;
    issue(OP_ADD, 5'd1, 5'd2, 5'd7, 1'b1, 32'h4110_0000, 32'h4222_0000, 32'h4246_0000, 1'b0);
    while (!res_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (!res_ready) begin
      tests_failed++;
      $display("FAIL abort_wait: res_ready=%b expected 1 within 20 cycles", res_ready);
    end
    reset = 1'b1;
    res_en = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({instr_ready, busy, rf, wf, ex_valid, res_ready} !== 6'b100000) begin
      tests_failed++;
      $display("FAIL abort_ctrl: got rdy/busy/rf/wf/exv/resr=%b expected 100000",
               {instr_ready, busy, rf, wf, ex_valid, res_ready});
    end
    tests_run++;
    if ({retire_count, ws, wd, rs1, rs2, ex_a, ex_b} !== '0) begin
      tests_failed++;
      $display("FAIL abort_data: got cnt=%h ws=%h wd=%h rs1=%h rs2=%h a=%h b=%h expected all 0",
               retire_count, ws, wd, rs1, rs2, ex_a, ex_b);
    end
    reset = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({instr_ready, regs[7]} !== {1'b1, 32'hAAAA_5555}) begin
      tests_failed++;
      $display("FAIL abort_after: got rdy=%b r7=%h expected rdy=1 r7=aaaa5555", instr_ready, regs[7]);
    end
  endtask

  task automatic test_wrap();
    for (int i = 1; i <= 16; i++) begin
      issue(OP_ADD, 5'd1, 5'd2, 5'd9, 1'b0, 32'h4110_0000, 32'h4222_0000, 32'h4246_0000, 1'b0);
      wait_idle();
      if (i == 15) begin
        tests_run++;
        if ({s_retire_count, retire_count} !== {4'hF, 16'd15}) begin
          tests_failed++;
          $display("FAIL wrap_full: got small=%h main=%0d expected small=f main=15",
                   s_retire_count, retire_count);
        end
      end
    end
    tests_run++;
    if ({s_retire_count, retire_count} !== {4'h0, 16'd16}) begin
      tests_failed++;
      $display("FAIL wrap_zero: got small=%h main=%0d expected small=0 main=16",
               s_retire_count, retire_count);
    end
  endtask

  initial begin
    test_reset();
    poke(5'd1, 32'h4110_0000);
    poke(5'd2, 32'h4222_0000);
    test_basic_add();
    test_stall();
    test_no_wb();
    test_hazard();
    test_reset_abort();
    test_wrap();
    repeat (3) @(negedge clk);
    tests_run++;
    if (exp_opnd.size() != 0 || exp_wr.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: %0d operand and %0d write entries left, expected 0 and 0",
               exp_opnd.size(), exp_wr.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
